// File: rtl/ext_int_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ext_int_ctrl_pkg
// Shared constants and the register decode helper for the external interrupt
// controller.
//   EIC_ID_W        width of a source ID (ID 0 = none)
//   EIC_BASE_ADDR   base of the controller window on the rib bus (SoC decode)
//   EIC_*           byte offsets inside the window (addr[7:0])
//   eic_reg_e       decoded register selector
//   eic_decode()    maps an offset to a register selector
// ---------------------------------------------------------------------------
package ext_int_ctrl_pkg;

    localparam int          EIC_ID_W      = 5;
    localparam logic [31:0] EIC_BASE_ADDR = 32'h0C00_0000;

    localparam logic [7:0]  EIC_PRIO_BASE = 8'h00;
    localparam logic [7:0]  EIC_PENDING   = 8'h80;
    localparam logic [7:0]  EIC_ENABLE    = 8'h84;
    localparam logic [7:0]  EIC_MODE      = 8'h88;
    localparam logic [7:0]  EIC_THRESH    = 8'h8C;
    localparam logic [7:0]  EIC_CLAIM     = 8'h90;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PRIO,
        REG_PENDING,
        REG_ENABLE,
        REG_MODE,
        REG_THRESH,
        REG_CLAIM
    } eic_reg_e;

    // Only word-aligned offsets are mapped. The priority slots occupy
    // 0x04..0x04*num_src; slot 0 (offset 0x00) is the reserved "ID 0".
    function automatic eic_reg_e eic_decode(input logic [7:0] offset, input int num_src);
        eic_reg_e sel;
        sel = REG_NONE;
        if (offset[1:0] == 2'b00) begin
            if (offset < EIC_PENDING) begin
                if (offset != EIC_PRIO_BASE && int'(offset[7:2]) <= num_src) begin
                    sel = REG_PRIO;
                end
            end else begin
                case (offset)
                    EIC_PENDING: sel = REG_PENDING;
                    EIC_ENABLE:  sel = REG_ENABLE;
                    EIC_MODE:    sel = REG_MODE;
                    EIC_THRESH:  sel = REG_THRESH;
                    EIC_CLAIM:   sel = REG_CLAIM;
                    default:     sel = REG_NONE;
                endcase
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ext_int_ctrl_if.sv
// ---------------------------------------------------------------------------
// ext_int_ctrl_if
// rib slave access bundle for the external interrupt controller.
//   req_i   access strobe (one access per cycle while high)
//   we_i    1 = write, 0 = read
//   addr_i  byte address, only [7:0] decoded by the slave
//   data_i  write data
//   data_o  combinational read data
// Modports: master drives the access, slave returns read data.
// ---------------------------------------------------------------------------
interface ext_int_ctrl_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output req_i,
        output we_i,
        output addr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  req_i,
        input  we_i,
        input  addr_i,
        input  data_i,
        output data_o
    );

endinterface

// File: rtl/eic_gateway.sv
// ---------------------------------------------------------------------------
// eic_gateway
// Per-source interrupt gateway: input synchroniser, rising-edge detector,
// pending flop and in-service flop.
//   clk, rst      clock, asynchronous active-low reset
//   src           raw (asynchronous) interrupt input
//   mode          1 = rising edge, 0 = level-high
//   claim_clr     this source is being claimed this cycle
//   complete_clr  a complete write names this source this cycle
//   pending       pending flag seen by the arbiter
// ---------------------------------------------------------------------------
module eic_gateway #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    input  logic claim_clr,
    input  logic complete_clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   pending_reg;
    logic                   in_service_reg;

    logic synced;
    logic rise;
    logic set_req;
    logic pending_next;
    logic in_service_next;

    assign synced = sync_reg[SYNC_STAGES-1];
    assign rise   = synced & ~prev_reg;

    always_comb begin
        // Edges are latched regardless of service state (extra edges merge
        // into the single pending bit). A level request is held off while
        // the source is in service or being claimed right now, otherwise
        // the still-high line would immediately re-pend the claimed source.
        set_req = mode ? rise : (synced & ~in_service_reg & ~claim_clr);

        // A set in the same cycle as a claim wins.
        pending_next = (pending_reg & ~claim_clr) | set_req;

        in_service_next = in_service_reg;
        if (claim_clr) begin
            in_service_next = 1'b1;
        end else if (complete_clr) begin
            in_service_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg       <= '0;
            prev_reg       <= 1'b0;
            pending_reg    <= 1'b0;
            in_service_reg <= 1'b0;
        end else begin
            // Shift towards the MSB; the size cast keeps this legal for a
            // single-stage synchroniser as well.
            sync_reg       <= SYNC_STAGES'({sync_reg, src});
            prev_reg       <= synced;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/ext_int_ctrl.sv
// ---------------------------------------------------------------------------
// ext_int_ctrl
// Prioritised external interrupt controller in front of the core's single
// external interrupt input.
//   clk       core clock
//   rst       asynchronous active-low reset
//   src_i     raw interrupt sources, bit k = ID k+1
//   bus       rib slave port (ext_int_ctrl_if.slave)
//   irq_o     registered interrupt request
//   irq_id_o  registered best ID (0 = none); returned by a claim read
// Registers (addr[7:0]): 0x04*i priority of ID i, 0x80 pending (RO),
// 0x84 enable, 0x88 mode (1 = edge), 0x8C threshold,
// 0x90 claim (read) / complete (write).
// ---------------------------------------------------------------------------
module ext_int_ctrl
    import ext_int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  src_i,
    ext_int_ctrl_if.slave       bus,
    output logic                irq_o,
    output logic [EIC_ID_W-1:0] irq_id_o
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [7:0]          offset;
    logic [5:0]          prio_idx;
    eic_reg_e            reg_sel;
    logic                rd_en;
    logic                wr_en;
    logic                claim_rd;
    logic                complete_wr;
    logic [EIC_ID_W-1:0] complete_id;

    assign offset      = bus.addr_i[7:0];
    assign prio_idx    = offset[7:2];
    assign reg_sel     = eic_decode(offset, NUM_SRC);
    assign rd_en       = bus.req_i & ~bus.we_i;
    assign wr_en       = bus.req_i & bus.we_i;
    assign claim_rd    = rd_en & (reg_sel == REG_CLAIM);
    assign complete_wr = wr_en & (reg_sel == REG_CLAIM);
    assign complete_id = bus.data_i[EIC_ID_W-1:0];

    // ------------------------------------------------------------------
    // Register file (index k holds ID k+1)
    // ------------------------------------------------------------------
    logic [PRIO_W-1:0]   prio_reg [NUM_SRC];
    logic [NUM_SRC-1:0]  enable_reg;
    logic [NUM_SRC-1:0]  mode_reg;
    logic [PRIO_W-1:0]   threshold_reg;
    logic [NUM_SRC-1:0]  pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                prio_reg[k] <= '0;
            end
            enable_reg    <= '0;
            mode_reg      <= '0;
            threshold_reg <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_PRIO: begin
                    for (int k = 0; k < NUM_SRC; k++) begin
                        if (prio_idx == 6'(k + 1)) begin
                            prio_reg[k] <= bus.data_i[PRIO_W-1:0];
                        end
                    end
                end
                REG_ENABLE: enable_reg    <= bus.data_i[NUM_SRC:1];
                REG_MODE:   mode_reg      <= bus.data_i[NUM_SRC:1];
                REG_THRESH: threshold_reg <= bus.data_i[PRIO_W-1:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Gateways
    // ------------------------------------------------------------------
    logic [EIC_ID_W-1:0] irq_id_reg;
    logic                irq_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            localparam logic [EIC_ID_W-1:0] SRC_ID = EIC_ID_W'(gi + 1);

            eic_gateway #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_gateway (
                .clk          (clk),
                .rst          (rst),
                .src          (src_i[gi]),
                .mode         (mode_reg[gi]),
                // The claim always targets the registered ID that the
                // claim read returns, never the live arbitration result.
                .claim_clr    (claim_rd && (irq_id_reg == SRC_ID)),
                .complete_clr (complete_wr && (complete_id == SRC_ID)),
                .pending      (pending[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbiter: highest priority above threshold, ties to the lowest ID.
    // Scanning upward and replacing only on a strictly higher priority
    // keeps the lowest ID among equals.
    // ------------------------------------------------------------------
    logic [EIC_ID_W-1:0] best_id;
    logic [PRIO_W-1:0]   best_prio;

    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pending[k] && enable_reg[k] &&
                (prio_reg[k] > threshold_reg) && (prio_reg[k] > best_prio)) begin
                best_id   = EIC_ID_W'(k + 1);
                best_prio = prio_reg[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_id_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            irq_id_reg <= best_id;
            irq_reg    <= (best_id != '0);
        end
    end

    assign irq_o    = irq_reg;
    assign irq_id_o = irq_id_reg;

    // ------------------------------------------------------------------
    // Read mux (combinational, zero unless a read is in progress)
    // ------------------------------------------------------------------
    logic [PRIO_W-1:0] prio_rd;
    logic [31:0]       rdata;

    always_comb begin
        prio_rd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (prio_idx == 6'(k + 1)) begin
                prio_rd = prio_reg[k];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_PRIO:    rdata[PRIO_W-1:0]   = prio_rd;
                REG_PENDING: rdata[NUM_SRC:1]    = pending;
                REG_ENABLE:  rdata[NUM_SRC:1]    = enable_reg;
                REG_MODE:    rdata[NUM_SRC:1]    = mode_reg;
                REG_THRESH:  rdata[PRIO_W-1:0]   = threshold_reg;
                REG_CLAIM:   rdata[EIC_ID_W-1:0] = irq_id_reg;
                default: ;
            endcase
        end
    end

    assign bus.data_o = rdata;

    // Address bits above the window and unused write-data bits are
    // deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.addr_i[31:8], bus.data_i};

endmodule

// File: tb/tb_ext_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ext_int_ctrl
// Directed scenarios followed by a randomized run. A behavioural model of
// the controller (plain arrays, priority search from the top level down)
// predicts read data, irq_o and irq_id_o every cycle.
// ---------------------------------------------------------------------------
module tb_ext_int_ctrl;
    import ext_int_ctrl_pkg::*;

    localparam int NUM_SRC     = 8;
    localparam int PRIO_W      = 3;
    localparam int SYNC_STAGES = 2;
    localparam int OP_IDLE     = 0;
    localparam int OP_READ     = 1;
    localparam int OP_WRITE    = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NUM_SRC-1:0]  src_i = '0;
    logic                irq_o;
    logic [EIC_ID_W-1:0] irq_id_o;

    ext_int_ctrl_if bus_if ();

    ext_int_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .PRIO_W      (PRIO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_i    (src_i),
        .bus      (bus_if.slave),
        .irq_o    (irq_o),
        .irq_id_o (irq_id_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [NUM_SRC:1]   pend_m, insvc_m, en_m, mode_m;
    int                 prio_m [1:NUM_SRC];
    int                 thr_m;
    int                 irq_id_m;
    // hist[0] = value driven for the coming edge, hist[j] = j edges earlier
    logic [NUM_SRC-1:0] hist [0:SYNC_STAGES+1];
    logic [31:0]        last_rd;

    function automatic void model_reset();
        pend_m = '0; insvc_m = '0; en_m = '0; mode_m = '0;
        thr_m = 0; irq_id_m = 0;
        for (int i = 1; i <= NUM_SRC; i++) prio_m[i] = 0;
        for (int j = 0; j <= SYNC_STAGES + 1; j++) hist[j] = '0;
    endfunction

    // Walk priorities from the top down; the first enabled pending ID found
    // at a level is the lowest ID of that priority.
    function automatic int model_best();
        int best = 0;
        for (int p = (1 << PRIO_W) - 1; p > thr_m; p--)
            for (int id = 1; id <= NUM_SRC; id++)
                if (best == 0 && pend_m[id] && en_m[id] && prio_m[id] == p) best = id;
        return best;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        logic [31:0] r = '0;
        int idx = int'(off[7:2]);
        if (off[1:0] == 2'b00 && off < 8'h80 && idx >= 1 && idx <= NUM_SRC) r = 32'(prio_m[idx]);
        else if (off == EIC_PENDING) r[NUM_SRC:1] = pend_m;
        else if (off == EIC_ENABLE)  r[NUM_SRC:1] = en_m;
        else if (off == EIC_MODE)    r[NUM_SRC:1] = mode_m;
        else if (off == EIC_THRESH)  r = 32'(thr_m);
        else if (off == EIC_CLAIM)   r = 32'(irq_id_m);
        return r;
    endfunction

    function automatic void model_step(input int op, input logic [7:0] off, input logic [31:0] wd);
        int  claim_id = (op == OP_READ && off == EIC_CLAIM) ? irq_id_m : 0;
        int  comp_id  = (op == OP_WRITE && off == EIC_CLAIM) ? int'(wd[4:0]) : 0;
        int  nb       = model_best();
        int  idx      = int'(off[7:2]);
        logic s, p, set;
        for (int id = 1; id <= NUM_SRC; id++) begin
            s   = hist[SYNC_STAGES][id-1];
            p   = hist[SYNC_STAGES+1][id-1];
            set = mode_m[id] ? (s && !p) : (s && !insvc_m[id] && claim_id != id);
            pend_m[id] = (pend_m[id] && claim_id != id) || set;
            if (claim_id == id) insvc_m[id] = 1'b1;
            else if (comp_id == id) insvc_m[id] = 1'b0;
        end
        if (op == OP_WRITE) begin
            if (off[1:0] == 2'b00 && off < 8'h80 && idx >= 1 && idx <= NUM_SRC)
                prio_m[idx] = int'(wd[PRIO_W-1:0]);
            else if (off == EIC_ENABLE) en_m   = wd[NUM_SRC:1];
            else if (off == EIC_MODE)   mode_m = wd[NUM_SRC:1];
            else if (off == EIC_THRESH) thr_m  = int'(wd[PRIO_W-1:0]);
        end
        irq_id_m = nb;
        for (int j = SYNC_STAGES + 1; j >= 1; j--) hist[j] = hist[j-1];
    endfunction

    // ------------------------------------------------------------------
    // One clock cycle: drive, check read data, clock, check irq outputs
    // ------------------------------------------------------------------
    task automatic cycle(input logic [NUM_SRC-1:0] src, input int op, input logic [7:0] off,
                         input logic [31:0] wd, input string tag);
        logic [31:0] a;
        a        = $urandom();
        a[7:0]   = off;
        src_i    = src;
        hist[0]  = src;
        bus_if.req_i  = (op != OP_IDLE);
        bus_if.we_i   = (op == OP_WRITE);
        bus_if.addr_i = a;
        bus_if.data_i = wd;
        #1;
        check_val({tag, ".rd"}, bus_if.data_o, (op == OP_READ) ? model_read(off) : 32'h0);
        last_rd = bus_if.data_o;
        if (op == OP_READ)  $display("%0t %s rd 0x%02h -> 0x%08h", $time, tag, off, bus_if.data_o);
        if (op == OP_WRITE) $display("%0t %s wr 0x%02h <- 0x%08h", $time, tag, off, wd);
        @(posedge clk);
        model_step(op, off, wd);
        #1;
        check_val({tag, ".irq"}, 32'(irq_o), 32'(irq_id_m != 0));
        check_val({tag, ".id"}, 32'(irq_id_o), 32'(irq_id_m));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        src_i = '0;
        bus_if.req_i = 1'b1; bus_if.we_i = 1'b0;
        bus_if.addr_i = EIC_BASE_ADDR | 32'(EIC_ENABLE);
        #1;
        check_val({tag, ".irq"}, 32'(irq_o), 32'h0);
        check_val({tag, ".id"}, 32'(irq_id_o), 32'h0);
        check_val({tag, ".en"}, bus_if.data_o, 32'h0);
        bus_if.addr_i = EIC_BASE_ADDR | 32'(EIC_PENDING);
        #1;
        check_val({tag, ".pend"}, bus_if.data_o, 32'h0);
        bus_if.req_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        $display("%0t %s reset", $time, tag);
    endtask

    logic [7:0] pool [15] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                              8'h20, 8'h24, 8'h80, 8'h84, 8'h88, 8'h8C, 8'h94};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_ids [3] = '{7, 2, 5};
        logic [NUM_SRC-1:0] src;
        int r, op;
        logic [7:0] off;
        logic [31:0] wd;

        bus_if.req_i = 1'b0; bus_if.we_i = 1'b0; bus_if.addr_i = '0; bus_if.data_i = '0;
        model_reset();
        @(posedge clk); #1;
        do_reset("rst0");

        // 1: all sources high, registers at reset -> pending but no irq
        repeat (SYNC_STAGES + 3) cycle('1, OP_IDLE, 8'h00, 0, "t1");
        cycle('1, OP_READ, EIC_PENDING, 0, "t1.pend");
        check_val("t1.pend_val", last_rd, 32'h1FE);
        cycle('1, OP_READ, EIC_CLAIM, 0, "t1.claim");
        check_val("t1.claim_val", last_rd, 32'h0);
        check_val("t1.irq_low", 32'(irq_o), 32'h0);

        // 2: level source ID 3, latency, claim, complete
        do_reset("t2");
        cycle('0, OP_WRITE, 8'h0C, 32'd2, "t2.prio");
        cycle('0, OP_WRITE, EIC_ENABLE, 32'h08, "t2.en");
        n = 0;
        do begin
            cycle(8'h04, OP_IDLE, 8'h00, 0, "t2.wait");
            n++;
        end while (!irq_o && n < 10);
        check_val("t2.latency", 32'(n), 32'(SYNC_STAGES + 2));
        check_val("t2.irq_id", 32'(irq_id_o), 32'd3);
        cycle(8'h04, OP_READ, EIC_CLAIM, 0, "t2.claim");
        check_val("t2.claim_val", last_rd, 32'd3);
        cycle(8'h04, OP_IDLE, 8'h00, 0, "t2.idle");
        check_val("t2.irq_after_claim", 32'(irq_o), 32'h0);
        cycle(8'h04, OP_READ, EIC_PENDING, 0, "t2.pend");
        check_val("t2.pend_val", last_rd, 32'h0);
        cycle(8'h04, OP_WRITE, EIC_CLAIM, 32'd3, "t2.complete");
        repeat (2) cycle(8'h04, OP_IDLE, 8'h00, 0, "t2.idle");
        check_val("t2.irq_again", 32'(irq_o), 32'h1);

        // 3: priority order and tie to lowest ID, then threshold
        for (int pass = 0; pass < 2; pass++) begin
            do_reset("t3");
            cycle('0, OP_WRITE, 8'h08, 32'd5, "t3.prio2");
            cycle('0, OP_WRITE, 8'h14, 32'd5, "t3.prio5");
            cycle('0, OP_WRITE, 8'h1C, 32'd6, "t3.prio7");
            cycle('0, OP_WRITE, EIC_ENABLE, 32'hA4, "t3.en");
            if (pass == 1) cycle(8'h52, OP_WRITE, EIC_THRESH, 32'd5, "t3.thr");
            repeat (SYNC_STAGES + 3) cycle(8'h52, OP_IDLE, 8'h00, 0, "t3.wait");
            for (int k = 0; k < 3; k++) begin
                cycle(8'h52, OP_READ, EIC_CLAIM, 0, "t3.claim");
                check_val("t3.claim_val", last_rd, (pass == 1 && k > 0) ? 32'h0 : 32'(exp_ids[k]));
                cycle(8'h52, OP_IDLE, 8'h00, 0, "t3.idle");
            end
        end
        // 6: drop threshold so ID 2 requests, then reset mid-operation
        cycle(8'h52, OP_WRITE, EIC_THRESH, 32'd0, "t6.thr");
        repeat (2) cycle(8'h52, OP_IDLE, 8'h00, 0, "t6.wait");
        check_val("t6.irq_pre", 32'(irq_o), 32'h1);
        do_reset("t6");
        for (int k = 0; k < 15; k++) cycle('0, OP_READ, pool[k], 0, "t6.regs");

        // 4/5: edge mode on ID 4
        cycle('0, OP_WRITE, EIC_MODE, 32'h10, "t4.mode");
        cycle('0, OP_WRITE, 8'h10, 32'd1, "t4.prio");
        cycle('0, OP_WRITE, EIC_ENABLE, 32'h10, "t4.en");
        cycle(8'h08, OP_IDLE, 8'h00, 0, "t4.p1");
        cycle(8'h00, OP_IDLE, 8'h00, 0, "t4.p1");
        cycle(8'h08, OP_IDLE, 8'h00, 0, "t4.p2");
        repeat (SYNC_STAGES + 3) cycle(8'h00, OP_IDLE, 8'h00, 0, "t4.wait");
        cycle('0, OP_READ, EIC_CLAIM, 0, "t4.claim");
        check_val("t4.claim_val", last_rd, 32'd4);
        cycle('0, OP_IDLE, 8'h00, 0, "t4.idle");
        cycle('0, OP_READ, EIC_PENDING, 0, "t4.pend");
        check_val("t4.pend_val", last_rd, 32'h0);
        cycle(8'h08, OP_IDLE, 8'h00, 0, "t4.p3");
        repeat (SYNC_STAGES + 3) cycle(8'h00, OP_IDLE, 8'h00, 0, "t4.wait");
        check_val("t4.irq_id", 32'(irq_id_o), 32'd4);
        // rise synced exactly on the claim edge: set wins
        cycle(8'h08, OP_IDLE, 8'h00, 0, "t5.rise");
        cycle(8'h08, OP_IDLE, 8'h00, 0, "t5.rise");
        cycle(8'h08, OP_READ, EIC_CLAIM, 0, "t5.claim");
        check_val("t5.claim_val", last_rd, 32'd4);
        cycle(8'h08, OP_READ, EIC_PENDING, 0, "t5.pend");
        check_val("t5.pend_val", last_rd, 32'h10);
        cycle(8'h08, OP_WRITE, EIC_CLAIM, 32'd6, "t5.complete6");
        cycle(8'h08, OP_READ, EIC_PENDING, 0, "t5.pend2");
        check_val("t5.pend_val2", last_rd, 32'h10);

        // Randomized run
        do_reset("rnd");
        src = '0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset("rnd.mid");
            src = src ^ NUM_SRC'($urandom() & $urandom() & $urandom());
            r  = $urandom_range(99);
            wd = $urandom();
            off = 8'h00;
            if (r < 30) op = OP_IDLE;
            else if (r < 50) begin op = OP_READ; off = EIC_CLAIM; end
            else if (r < 60) begin op = OP_WRITE; off = EIC_CLAIM; wd = 32'($urandom_range(0, 10)); end
            else begin
                op  = (r < 75) ? OP_READ : OP_WRITE;
                off = pool[$urandom_range(0, 14)];
                if (off == EIC_THRESH) wd[2:0] = 3'($urandom_range(0, 2));
            end
            cycle(src, op, off, wd, "rnd");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
